// File: rtl/whirlpool_cipher_iter_if.sv
// Job handshake bundle for the iterative Whirlpool cipher.
// 512-bit buses carry bytes MSB-first: bits [511:504] are byte 0, bit 511 is its MSB.
interface whirlpool_cipher_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_key;
   logic [511:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_data;

   modport master (output in_valid, in_key, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_key, in_data, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/whirlpool_cipher_iter.sv
// Iterative Whirlpool block cipher W with optional Miyaguchi-Preneel feedforward.
// UNROLL key/state round pairs are evaluated per clock.
//
// state | meaning
// IDLE  | waiting for a job, in_ready high
// RUN   | advancing UNROLL rounds per cycle on key and state
// DONE  | result held on out_data until out_ready
module whirlpool_cipher_iter #(
   parameter int UNROLL         = 1,
   parameter int MP_FEEDFORWARD = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   whirlpool_cipher_iter_if.slave bus
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
      $error("whirlpool_cipher_iter: UNROLL must be 1, 2, 5 or 10");
   end

   // Mini-box tables (E, E^-1, R) build the 8-bit S-box; C_TAB is the circulant row.
   localparam logic [63:0] E_TAB  = 64'h1B9CD6F3E874A250;
   localparam logic [63:0] EI_TAB = 64'hF0D7BE5A92C13486;
   localparam logic [63:0] R_TAB  = 64'h7CBDE49F638A2510;
   localparam logic [63:0] C_TAB  = 64'h1141852900000000;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   function automatic logic [3:0] nib(input logic [63:0] tab, input logic [3:0] i);
      return tab[4*(15-i) +: 4];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [3:0] a, b, r;
      a = nib(E_TAB, x[7:4]);
      b = nib(EI_TAB, x[3:0]);
      r = nib(R_TAB, a ^ b);
      return {nib(E_TAB, a ^ r), nib(EI_TAB, b ^ r)};
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xt(x);
      x4 = xt(x2);
      x8 = xt(x4);
      return ({8{c[0]}} & x) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
   endfunction

   // gamma, pi, theta, sigma on an 8x8 byte matrix stored row-major
   function automatic logic [511:0] wround(input logic [511:0] a, input logic [511:0] k);
      logic [7:0]   g [64];
      logic [7:0]   p [64];
      logic [7:0]   acc;
      logic [511:0] o;
      o = '0;
      for (int n = 0; n < 64; n++) g[n] = sbox(a[511-8*n -: 8]);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            p[8*i+j] = g[8*((i-j)&7)+j];
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            acc = k[511-8*(8*i+j) -: 8];
            for (int c = 0; c < 8; c++)
               acc = acc ^ gmul(p[8*i+c], nib(C_TAB, 4'((j-c)&7)));
            o[511-8*(8*i+j) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [511:0] rc(input logic [3:0] r);
      logic [511:0] o;
      logic [7:0]   base;
      o    = '0;
      base = {1'b0, r - 4'd1, 3'b000};
      for (int j = 0; j < 8; j++) o[511-8*j -: 8] = sbox(base + 8'(j));
      return o;
   endfunction

   fsm_t         fsm_q;
   logic         in_ready_q, out_valid_q;
   logic [3:0]   cnt_q, cnt_d;
   logic [511:0] key_q, blk_q, h_q, m_q, out_data_q;
   logic [511:0] key_d, blk_d, result_d;

   for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
      logic [511:0] k_in, s_in, k_out, s_out;
      if (u == 0) begin : g_first
         assign k_in = key_q;
         assign s_in = blk_q;
      end else begin : g_next
         assign k_in = g_rnd[u-1].k_out;
         assign s_in = g_rnd[u-1].s_out;
      end
      assign k_out = wround(k_in, rc(cnt_q + 4'(u + 1)));
      assign s_out = wround(s_in, k_out);
   end

   assign key_d    = g_rnd[UNROLL-1].k_out;
   assign blk_d    = g_rnd[UNROLL-1].s_out;
   assign cnt_d    = cnt_q + 4'(UNROLL);
   assign result_d = (MP_FEEDFORWARD != 0) ? (blk_d ^ h_q ^ m_q) : blk_d;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= 4'd0;
         key_q       <= '0;
         blk_q       <= '0;
         h_q         <= '0;
         m_q         <= '0;
         out_data_q  <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  key_q      <= bus.in_key;
                  blk_q      <= bus.in_data ^ bus.in_key;
                  h_q        <= bus.in_key;
                  m_q        <= bus.in_data;
                  cnt_q      <= 4'd0;
                  in_ready_q <= 1'b0;
                  fsm_q      <= RUN;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            RUN: begin
               key_q <= key_d;
               blk_q <= blk_d;
               cnt_q <= cnt_d;
               if (cnt_d == 4'd10) begin
                  out_data_q  <= result_d;
                  out_valid_q <= 1'b1;
                  fsm_q       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  fsm_q       <= IDLE;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_whirlpool_cipher_iter.sv
// Directed bench: five cipher instances (UNROLL 1/2/5/10 with feedforward, UNROLL 1 raw)
// checked against the Whirlpool("") digest.
module tb_whirlpool_cipher_iter;
   localparam int N = 5;
   localparam logic [511:0] H_EMPTY = 512'h19FA61D75522A466_9B44E39C1D2E1726_C530232130D407F8_9AFEE0964997F7A7_3E83BE698B288FEB_CF88E3E03C4F0757_EA8964E59B63D937_08B138CC42A66EB3;
   localparam logic [511:0] M_EMPTY = {8'h80, 504'd0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid  [N];
   logic         in_ready  [N];
   logic [511:0] in_key    [N];
   logic [511:0] in_data   [N];
   logic         out_valid [N];
   logic         out_ready [N];
   logic [511:0] out_data  [N];
   logic [511:0] last_out  [N];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      whirlpool_cipher_iter_if bus ();
      assign bus.in_valid  = in_valid[g];
      assign bus.in_key    = in_key[g];
      assign bus.in_data   = in_data[g];
      assign bus.out_ready = out_ready[g];
      assign in_ready[g]   = bus.in_ready;
      assign out_valid[g]  = bus.out_valid;
      assign out_data[g]   = bus.out_data;
      whirlpool_cipher_iter #(
         .UNROLL        (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : g == 3 ? 10 : 1),
         .MP_FEEDFORWARD(g == 4 ? 0 : 1)
      ) u_dut (
         .clk  (clk),
         .rst_n(rst_n),
         .bus  (bus)
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int idx, input logic [511:0] key, input logic [511:0] data,
                          input logic [511:0] exp, input int lat, input string name);
      int cyc;
      checks++;
      if (in_ready[idx] !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before: in_ready=%b required 1", name, in_ready[idx]);
      end
      in_valid[idx] = 1'b1;
      in_key[idx]   = key;
      in_data[idx]  = data;
      tick();
      in_valid[idx] = 1'b0;
      in_key[idx]   = '1;
      in_data[idx]  = '1;
      cyc = 0;
      while (out_valid[idx] !== 1'b1 && cyc < 40) begin
         checks++;
         if (out_data[idx] !== last_out[idx] || in_ready[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s run_hold: cycle %0d in_ready=%b out_data=%h required in_ready 0 out_data %h",
                     name, cyc, in_ready[idx], out_data[idx], last_out[idx]);
         end
         tick();
         cyc++;
      end
      checks++;
      if (cyc != lat) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles required %0d", name, cyc, lat);
      end
      checks++;
      if (out_data[idx] !== exp) begin
         errors++;
         $display("FAIL %s data: got %h required %h", name, out_data[idx], exp);
      end
      checks++;
      if (in_ready[idx] !== 1'b0) begin
         errors++;
         $display("FAIL %s done_ready: in_ready=%b required 0", name, in_ready[idx]);
      end
      last_out[idx]  = exp;
      out_ready[idx] = 1'b1;
      tick();
      out_ready[idx] = 1'b0;
      checks++;
      if (out_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1) begin
         errors++;
         $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0 and 1",
                  name, out_valid[idx], in_ready[idx]);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         in_valid[i]  = 1'b0;
         in_key[i]    = '0;
         in_data[i]   = '0;
         out_ready[i] = 1'b0;
         last_out[i]  = '0;
      end
      rst_n = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_valid[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid[%0d]: got %b required 0", i, out_valid[i]);
         end
         checks++;
         if (out_data[i] !== 512'd0) begin
            errors++;
            $display("FAIL reset_out_data[%0d]: got %h required 0", i, out_data[i]);
         end
      end
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (in_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready[%0d]: got %b required 1", i, in_ready[i]);
         end
      end
   endtask

   task automatic test_unroll();
      run_job(0, '0, M_EMPTY, H_EMPTY, 10, "unroll1");
      run_job(1, '0, M_EMPTY, H_EMPTY, 5, "unroll2");
      run_job(2, '0, M_EMPTY, H_EMPTY, 2, "unroll5");
      run_job(3, '0, M_EMPTY, H_EMPTY, 1, "unroll10");
   endtask

   task automatic test_no_feedforward();
      run_job(4, '0, M_EMPTY, H_EMPTY ^ M_EMPTY, 10, "raw_cipher");
   endtask

   task automatic test_stall();
      int  cyc;
      bit  saw;
      in_valid[0] = 1'b1;
      in_key[0]   = '0;
      in_data[0]  = M_EMPTY;
      tick();
      in_valid[0] = 1'b0;
      cyc = 0;
      while (out_valid[0] !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc != 10) begin
         errors++;
         $display("FAIL stall_latency: got %0d cycles required 10", cyc);
      end
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin
            in_valid[0] = 1'b1;
            in_key[0]   = '1;
            in_data[0]  = '1;
         end else begin
            in_valid[0] = 1'b0;
         end
         tick();
         checks++;
         if (out_valid[0] !== 1'b1 || out_data[0] !== H_EMPTY || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d out_valid=%b in_ready=%b out_data=%h required 1 0 %h",
                     c, out_valid[0], in_ready[0], out_data[0], H_EMPTY);
         end
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      last_out[0]  = H_EMPTY;
      saw = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (out_valid[0] === 1'b1) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL stall_ignored_pulse: out_valid_seen=%b in_ready=%b required 0 and 1",
                  saw, in_ready[0]);
      end
   endtask

   task automatic test_back_to_back(input int idx, input int lat);
      int   cyc, last_acc, res_cnt;
      logic was_ready;
      in_valid[idx]  = 1'b1;
      in_key[idx]    = '0;
      in_data[idx]   = M_EMPTY;
      out_ready[idx] = 1'b1;
      cyc      = 0;
      last_acc = -1;
      res_cnt  = 0;
      while (res_cnt < 3 && cyc < 200) begin
         was_ready = in_ready[idx];
         tick();
         cyc++;
         if (was_ready === 1'b1) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != lat + 2) begin
                  errors++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                           idx, cyc - last_acc, lat + 2);
               end
            end
            last_acc = cyc;
         end
         if (out_valid[idx] === 1'b1) begin
            checks++;
            if (out_data[idx] !== H_EMPTY) begin
               errors++;
               $display("FAIL b2b_data[%0d]: got %h required %h", idx, out_data[idx], H_EMPTY);
            end
            res_cnt++;
         end
      end
      checks++;
      if (res_cnt != 3) begin
         errors++;
         $display("FAIL b2b_results[%0d]: got %0d results required 3", idx, res_cnt);
      end
      in_valid[idx] = 1'b0;
      tick();
      out_ready[idx] = 1'b0;
      last_out[idx]  = H_EMPTY;
      repeat (lat + 2) tick();
      if (out_valid[idx] === 1'b1) begin
         out_ready[idx] = 1'b1;
         tick();
         out_ready[idx] = 1'b0;
      end
   endtask

   task automatic test_reset_mid_run();
      bit saw;
      in_valid[0] = 1'b1;
      in_key[0]   = '0;
      in_data[0]  = M_EMPTY;
      tick();
      in_valid[0] = 1'b0;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || out_data[0] !== 512'd0) begin
         errors++;
         $display("FAIL async_reset: out_valid=%b out_data=%h required 0 and 0",
                  out_valid[0], out_data[0]);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) last_out[i] = '0;
      saw = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (c == 0) begin
            checks++;
            if (in_ready[0] !== 1'b1) begin
               errors++;
               $display("FAIL mid_run_ready: in_ready=%b required 1", in_ready[0]);
            end
         end
         if (out_valid[0] === 1'b1) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_abandon: out_valid_seen=%b required 0", saw);
      end
      run_job(0, '0, M_EMPTY, H_EMPTY, 10, "after_reset");
   endtask

   initial begin
      test_reset();
      test_unroll();
      test_no_feedforward();
      test_stall();
      test_back_to_back(3, 1);
      test_back_to_back(0, 10);
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/whirlpool_cipher_iter.md
WHIRLPOOL_CIPHER_ITER -- requirements
Module: whirlpool_cipher_iter

Interface
REQ-001 Parameter UNROLL, default 1: cipher rounds computed per clock; legal values 1, 2, 5, 10; any other value SHALL fail elaboration.
REQ-002 Parameter MP_FEEDFORWARD, default 1: 1 selects Miyaguchi-Preneel output E_H(m)^m^H; 0 selects raw cipher output E_H(m).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_key/in_data valid.
REQ-006 in_ready  output  1  block can accept a job.
REQ-007 in_key  input  [0:511]  cipher key / chaining value H, bit 0 = MSB of byte 0.
REQ-008 in_data  input  [0:511]  plaintext / message block m, same byte order.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  [0:511]  result, same byte order.

Function
REQ-012 The block SHALL implement the 10-round Whirlpool cipher W: key K0=H, state S0=m^K0; for r=1..10: K_r=round(K_{r-1},RC_r), S_r=round(S_r-1,K_r); each round is gamma, pi, theta, sigma, in that order.
REQ-013 RC_r row 0 SHALL be 8 S-box bytes S[8(r-1)..8(r-1)+7]; rows 1-7 zero; RC_1 row 0 = 1823c6e887b8014f, RC_10 row 0 = ca2dbf07ad5a8333.
REQ-014 Datapath SHALL instantiate UNROLL key-round and UNROLL state-round stages in series; one iteration per cycle.
REQ-015 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, register K0=in_key, S0=in_data^in_key, latch H and m for feedforward, clear round counter, go RUN.
REQ-017 RUN: in_ready=0; each cycle advance UNROLL rounds, counter += UNROLL; when counter reaches 10 on that edge, load out_data and go DONE.
REQ-018 Latency: out_valid SHALL rise exactly 10/UNROLL cycles after the accepting edge (10, 5, 2, 1).
REQ-019 DONE: out_valid=1, out_data stable, in_ready=0; on out_ready, go IDLE with out_valid=0 next cycle.
REQ-020 No accept in the same cycle as the out handshake; minimum job spacing is 10/UNROLL+2 cycles.
REQ-021 in_valid while in_ready=0 SHALL be ignored; inputs sampled only on the accepting edge.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 Round counter SHALL be 4 bits, never exceed 10, no wrap.
REQ-024 out_data SHALL hold its last value in IDLE and RUN; only the DONE-entry edge updates it.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, out_valid=0, counter=0, out_data=0, key/state registers=0; in_ready=1 from first edge after release.
REQ-026 Reset mid-RUN or mid-DONE SHALL abandon the job with no out_valid pulse.

Verification
REQ-027 MP_FEEDFORWARD=1, UNROLL=1, H=0, m=80 followed by 63 zero bytes -> out_data=19FA61D75522A466 9B44E39C1D2E1726 C530232130D407F8 9AFEE0964997F7A7 3E83BE698B288FEB CF88E3E03C4F0757 EA8964E59B63D937 08B138CC42A66EB3 (Whirlpool("")), out_valid 10 cycles after accept.
REQ-028 Same vector, UNROLL=2,5,10 -> identical out_data; latency 5, 2, 1 cycles.
REQ-029 MP_FEEDFORWARD=0, same vector -> out_data = REQ-027 value ^ m; must match the software model.
REQ-030 out_ready held low 20 cycles in DONE -> out_valid, out_data stable; in_ready=0; a second in_valid pulse is ignored.
REQ-031 Back-to-back jobs with in_valid constantly high and out_ready=1 -> accepts spaced 10/UNROLL+2 cycles; each result matches the model.
REQ-032 rst_n pulsed low at cycle 4 of RUN -> out_valid never rises, in_ready=1 after release, next job produces the correct result.
